// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution datapath: default window/pixel
// constants, counter-width helper and the window element index used by the
// window generator, the calculator and the weight loader.
//
// Contents:
//   CONV_WIN_IDX(r, c, k) - window element index r*k + c (r = row, c = column)
//   KERNEL_DEF, N_DEF, IMG_W_DEF, IMG_H_DEF - default parameter values
//   cnt_width(depth)     - width of a counter that counts 0..depth-1
//   win_idx(r, c, k)     - function form of CONV_WIN_IDX
// -----------------------------------------------------------------------------
`ifndef CONV_WIN_IDX
`define CONV_WIN_IDX(r, c, k) ((r) * (k) + (c))
`endif

package conv_pkg;

  localparam int KERNEL_DEF = 3;
  localparam int N_DEF      = 4;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;

  // A depth of 1 still needs a 1-bit counter so the port/array ranges stay legal.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int win_idx(input int r, input int c, input int k);
    return `CONV_WIN_IDX(r, c, k);
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
// Pixel-stream in / window-stream out bundle of the sliding-window generator.
//
// Parameters: KERNEL (window side), N (pixel width)
// Signals:
//   pix_in     N               input pixel
//   en_in      1               pix_in valid this cycle
//   sof        1               start of frame, qualified by en_in
//   data2conv  KERNEL*KERNEL*N packed window, element i at [i*N +: N]
//   en_out     1               one-cycle strobe, data2conv valid
//   eof_out    1               last window of a frame (CONV_WIN_EOF_EN only)
// Modports: master = pixel source / window consumer, slave = window generator.
// -----------------------------------------------------------------------------
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int KERNEL = KERNEL_DEF,
  parameter int N      = N_DEF
);

  logic [N-1:0]               pix_in;
  logic                       en_in;
  logic                       sof;
  logic [KERNEL*KERNEL*N-1:0] data2conv;
  logic                       en_out;
`ifdef CONV_WIN_EOF_EN
  logic                       eof_out;
`endif

  modport master (
    output pix_in, en_in, sof,
    input  data2conv, en_out
`ifdef CONV_WIN_EOF_EN
    , input eof_out
`endif
  );

  modport slave (
    input  pix_in, en_in, sof,
    output data2conv, en_out
`ifdef CONV_WIN_EOF_EN
    , output eof_out
`endif
  );

endinterface

// File: rtl/conv_line_buf.sv
// -----------------------------------------------------------------------------
// conv_line_buf
// One image line of pixel storage. Write is registered; read is combinational
// at the same address so the previous-line pixel at the current column is
// available in the cycle the new pixel overwrites it.
//
// Parameters: N (pixel width), IMG_W (pixels per line), AW (address width)
// Ports:
//   clk      in   clock
//   we_i     in   write enable (accepted pixel)
//   addr_i   in   column address
//   wdata_i  in   pixel to store
//   rdata_o  out  pixel currently stored at addr_i
// -----------------------------------------------------------------------------
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int AW    = cnt_width(IMG_W)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [N-1:0]  wdata_i,
  output logic [N-1:0]  rdata_o
);

  // Contents are never reset: stale data is masked by the row gating upstream.
  logic [N-1:0] mem_q [IMG_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Sliding-window generator: turns a row-major pixel stream into packed
// KERNEL x KERNEL windows, one per valid window position, each flagged by a
// one-cycle en_out strobe the cycle after the completing pixel.
//
// Parameters: KERNEL (1/3/5/7), N (pixel bits), IMG_W, IMG_H (>= KERNEL)
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset
//   bus   slave modport of conv_window_gen_if (pix_in, en_in, sof in;
//         data2conv, en_out[, eof_out] out)
// Optional feature: define CONV_WIN_EOF_EN to add eof_out, which flags the
// window completed by pixel (IMG_H-1, IMG_W-1).
// -----------------------------------------------------------------------------
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int KERNEL = KERNEL_DEF,
  parameter int N      = N_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input logic             clk,
  input logic             rst,
  conv_window_gen_if.slave bus
);

  localparam int CW  = cnt_width(IMG_W);
  localparam int RW  = cnt_width(IMG_H);
  localparam int WW  = KERNEL * KERNEL * N;
  localparam int NLB = (KERNEL > 1) ? KERNEL - 1 : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [N-1:0]  win_q [KERNEL][KERNEL];
  logic [N-1:0]  win_d [KERNEL][KERNEL];
  logic [N-1:0]  colv  [KERNEL];
  logic [N-1:0]  lb_rd [NLB];
  logic [WW-1:0] data_q, data_d;
  logic          en_out_q, en_out_d;
  logic          accept;
  logic          win_valid;

  assign accept = bus.en_in;

  // sof relocates the accepted pixel to (0,0); counters continue from there.
  assign cur_col = (bus.en_in && bus.sof) ? '0 : col_q;
  assign cur_row = (bus.en_in && bus.sof) ? '0 : row_q;

  // Line buffers form a vertical shift chain at the current column:
  // lb[0] holds the previous line, lb[KERNEL-2] the oldest one.
  generate
    if (KERNEL > 1) begin : g_lb
      for (genvar gi = 0; gi < KERNEL - 1; gi++) begin : g_line
        logic [N-1:0] wdata;
        if (gi == 0) begin : g_first
          assign wdata = bus.pix_in;
        end else begin : g_chain
          assign wdata = lb_rd[gi-1];
        end
        conv_line_buf #(
          .N     (N),
          .IMG_W (IMG_W),
          .AW    (CW)
        ) u_line_buf (
          .clk     (clk),
          .we_i    (accept),
          .addr_i  (cur_col),
          .wdata_i (wdata),
          .rdata_o (lb_rd[gi])
        );
        // Oldest line goes to the top of the column (r = 0).
        assign colv[KERNEL-2-gi] = lb_rd[gi];
      end
      assign win_valid = (cur_row >= RW'(KERNEL - 1)) && (cur_col >= CW'(KERNEL - 1));
    end else begin : g_no_lb
      assign lb_rd[0]  = '0;
      assign win_valid = 1'b1;
    end
  endgenerate

  assign colv[KERNEL-1] = bus.pix_in;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    data_d   = data_q;
    en_out_d = 1'b0;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      // Columns age toward c = 0; the fresh column enters on the right.
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KERNEL-1] = colv[r];
      end
      // Output register only loads on a real window so it holds between strobes.
      if (win_valid) begin
        en_out_d = 1'b1;
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL; c++) begin
            data_d[`CONV_WIN_IDX(r, c, KERNEL)*N +: N] = win_d[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q    <= '0;
      row_q    <= '0;
      data_q   <= '0;
      en_out_q <= 1'b0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      data_q   <= data_d;
      en_out_q <= en_out_d;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  assign bus.data2conv = data_q;
  assign bus.en_out    = en_out_q;

`ifdef CONV_WIN_EOF_EN
  logic eof_q, eof_d;

  assign eof_d = accept && win_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eof_q <= 1'b0;
    end else begin
      eof_q <= eof_d;
    end
  end

  assign bus.eof_out = eof_q;
`endif

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator that turns a raster pixel stream into KERNEL×KERNEL windows for the convolution calculator. It is the producer side of the `data2conv`/`en_in` interface. Pixels arrive one per enabled cycle in row-major order. The block buffers KERNEL-1 lines, and for every valid window position it emits one packed window on `data2conv` with a one-cycle `en_out` strobe. `en_out` wires directly to the calculator's `en_in`.

## Interface
Parameters:
- KERNEL, 3, window side (1/3/5/7)
- N, 4, pixel width in bits
- IMG_W, 8, pixels per line (≥ KERNEL)
- IMG_H, 8, lines per frame (≥ KERNEL)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- pix_in  in  N  input pixel
- en_in  in  1  pix_in valid this cycle
- sof  in  1  start of frame; qualifies the pixel on the same cycle, or is ignored when en_in=0
- data2conv  out  KERNEL*KERNEL*N  packed window, element i at [i*N +: N]
- en_out  out  1  data2conv valid, one-cycle strobe per window
- eof_out  out  1  only when CONV_WIN_EOF_EN is defined; marks the last window of a frame

## Operation
- **Counters.**
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing only on en_in=1.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 with col=IMG_W-1, both wrap to 0 (the next frame starts implicitly).
- **Start of frame.** sof=1 with en_in=1: the pixel is treated as row 0, col 0, and the counters continue from there. This holds mid-frame too; the partial frame is discarded.
- **Line buffers.** KERNEL-1 line memories, each IMG_W×N, addressed by col. On an accepted pixel:
  - the column vector is {lb[K-2][col], …, lb[0][col], pix_in}, oldest row first;
  - then lb[0][col]←pix_in and lb[k][col]←lb[k-1][col].
- **Window register.** KERNEL×KERNEL×N. On an accepted pixel the columns shift toward c=0, and the new column enters at c=KERNEL-1.
- **Packing.** Element index i = r*KERNEL + c.
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
  - Element i pairs with weight i of the calculator.
- **Window valid.** Evaluated with the pre-increment (row, col) of the accepted pixel: row ≥ KERNEL-1 and col ≥ KERNEL-1.
  - Windows per frame: (IMG_W-KERNEL+1)·(IMG_H-KERNEL+1).
  - No window ever spans a line wrap.
- **Idle cycles.** en_in=0: no state change, en_out=0, and data2conv holds its last value.
- **KERNEL=1.** Line buffers are absent; every pixel yields a window.

## Timing
- **Reset (rst=0, asynchronous).** col=0, row=0, window register=0, data2conv=0, en_out=0, eof_out=0.
  - Line-buffer contents are not reset; they are unobservable because output is gated by row.
  - Reset mid-frame restarts at row 0, col 0 on the first en_in after release.
- **Latency.** en_out rises the cycle after the en_in cycle that accepts the window-completing pixel. data2conv is registered and valid in that same cycle.
- **Throughput.** One pixel per cycle, so at most one window per cycle. There is no backpressure; the consumer must accept every en_out.

## Configuration
- **CONV_WIN_EOF_EN defined:**
  - eof_out exists;
  - it is asserted together with en_out for the window completed by pixel (IMG_H-1, IMG_W-1);
  - otherwise it is 0.
- **Undefined:** the port and its logic are absent; behaviour is otherwise identical.

## Structure
- **Shared package conv_pkg:**
  - default KERNEL/N constants;
  - col/row counter widths as clog2(IMG_W) and clog2(IMG_H);
  - the window-index macro r*KERNEL+c, shared with the calculator and the weight loader.
- **Sub-module conv_line_buf:** one IMG_W×N line memory with a registered write and a combinational read at address col, instantiated KERNEL-1 times in a generate loop.

## Test plan
All scenarios use KERNEL=3, N=4, IMG_W=5, IMG_H=4, with pixel value = (row·5+col) mod 16.
- **Continuous frame.** en_in=1 for 20 cycles with sof on the first → 6 en_out strobes. The first appears the cycle after pixel 12, with elements 0..8 = 0,1,2,5,6,7,10,11,12. The last window is 7,8,9,12,13,14,17→1,18→2,19→3.
- **Gapped input.** en_in toggles 1/0 → the same 6 windows with identical data; en_out is never set on an idle cycle; data2conv holds between strobes.
- **sof mid-frame.** sof asserted at pixel 8 of frame 1, then 20 pixels → no window until the new row 2, col 2; then 6 windows.
- **Reset mid-frame.** rst pulled low at pixel 11 → en_out=0 and data2conv=0 immediately (asynchronously). The next 20 pixels yield exactly 6 windows.
- **Back-to-back frames.** 40 pixels, sof only on the first → 12 windows. With CONV_WIN_EOF_EN, eof_out=1 on window 6 and window 12 only.
- **KERNEL=1, IMG_W=IMG_H=2.** 4 pixels → 4 strobes with data2conv=pix_in, each one cycle later.
